// File: rtl/rvb_shifter_issue_if.sv
// -----------------------------------------------------------------------------
// rvb_shifter_issue_if
// Handshake bundle between the instruction source, the shifter issue stage and
// the shifter's din_* port.
//   in_*    : raw instruction word plus operands (valid/ready)
//   dout_*  : buffered, decoded entry toward the shifter (valid/ready)
//   err_*   : illegal-instruction report from the issue stage
// Modports:
//   master : the source/sink side (drives in_*, dout_ready)
//   slave  : the issue stage itself
// -----------------------------------------------------------------------------
interface rvb_shifter_issue_if #(
  parameter int XLEN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_insn;
  logic [XLEN-1:0] in_rs1;
  logic [XLEN-1:0] in_rs2;
  logic [XLEN-1:0] in_rs3;

  logic            dout_valid;
  logic            dout_ready;
  logic [XLEN-1:0] dout_rs1;
  logic [XLEN-1:0] dout_rs2;
  logic [XLEN-1:0] dout_rs3;
  logic            dout_insn3;
  logic            dout_insn14;
  logic            dout_insn26;
  logic            dout_insn27;
  logic            dout_insn29;
  logic            dout_insn30;

  logic            err_valid;
  logic [31:0]     err_insn;

  modport master (
    output in_valid, in_insn, in_rs1, in_rs2, in_rs3, dout_ready,
    input  in_ready, dout_valid, dout_rs1, dout_rs2, dout_rs3,
           dout_insn3, dout_insn14, dout_insn26, dout_insn27, dout_insn29, dout_insn30,
           err_valid, err_insn
  );

  modport slave (
    input  in_valid, in_insn, in_rs1, in_rs2, in_rs3, dout_ready,
    output in_ready, dout_valid, dout_rs1, dout_rs2, dout_rs3,
           dout_insn3, dout_insn14, dout_insn26, dout_insn27, dout_insn29, dout_insn30,
           err_valid, err_insn
  );
endinterface

// File: rtl/rvb_shifter_issue.sv
// -----------------------------------------------------------------------------
// rvb_shifter_issue
// Issue stage in front of the bitmanip shifter. Decodes the raw instruction
// word into the six control bits the shifter uses (insn3/14/26/27/29/30),
// substitutes the shift immediate for I-type forms, drops encodings the
// shifter does not implement (reporting them on err_*), and queues legal ops
// in a 2-entry pointer FIFO whose head register drives dout_*.
//
// Ports:
//   clock       positive-edge clock
//   resetn      asynchronous, active-low reset
//   bus         rvb_shifter_issue_if.slave (in_*, dout_*, err_*)
//   perf_*      32-bit event counters, only with RVB_SHIFTER_ISSUE_PERF_EN
//
// Parameters:
//   XLEN  datapath width, 32 or 64
//   SBOP  single-bit ops (SBSET/SBCLR/SBINV/SBEXT) accepted
//   BFP   bit-field place accepted
//
// Optional feature macro: RVB_SHIFTER_ISSUE_PERF_EN
//   defined   -> perf_issued / perf_illegal / perf_stall outputs exist
//   undefined -> no counters, no extra ports
// -----------------------------------------------------------------------------
module rvb_shifter_issue #(
  parameter int XLEN = 64,
  parameter bit SBOP = 1'b1,
  parameter bit BFP  = 1'b1
) (
  input  logic                clock,
  input  logic                resetn,
  rvb_shifter_issue_if.slave  bus
`ifdef RVB_SHIFTER_ISSUE_PERF_EN
  ,
  output logic [31:0]         perf_issued,
  output logic [31:0]         perf_illegal,
  output logic [31:0]         perf_stall
`endif
);

  localparam logic       IS_RV64       = (XLEN == 32'sd64);
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;

  // ctrl packs {insn3, insn14, insn26, insn27, insn29, insn30}
  typedef struct packed {
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [XLEN-1:0] rs3;
    logic [5:0]      ctrl;
  } entry_t;

  // Shifter function table on {insn30, insn29, insn27, insn26, insn14}:
  //   00000 SLL    00001 SRL    10001 SRA
  //   01000 SLO    01001 SRO    11000 ROL    11001 ROR
  //   00100 SLLIU.W             00101 BFP
  //   01100 SBSET  10100 SBCLR  11100 SBINV  10101 SBEXT
  //   xxx1x FSL/FSR (insn30/29/27 belong to the rs3 field there)
  // Everything else with insn26=0 (SRA-class with insn14=0, SBSET/SBINV with
  // insn14=1) is not a shifter op.
  function automatic logic is_legal(input logic [31:0] insn);
    logic       opc_ok;
    logic       f3_ok;
    logic       func_ok;
    logic       rol_imm;
    logic       w_bad;
    logic [4:0] tup;
    tup = {insn[30], insn[29], insn[27], insn[26], insn[14]};
    case (insn[6:0])
      OPC_OP, OPC_OP_IMM, OPC_OP_32, OPC_OP_IMM_32: opc_ok = 1'b1;
      default:                                      opc_ok = 1'b0;
    endcase
    // funct3 001 or 101: bit 14 is free, it selects left/right
    f3_ok = (insn[13:12] == 2'b01);
    if (insn[26]) begin
      func_ok = 1'b1;
    end else begin
      case (tup)
        5'b00000, 5'b00001, 5'b10001,
        5'b01000, 5'b01001, 5'b11000, 5'b11001: func_ok = 1'b1;
        5'b00100: func_ok = IS_RV64 && (insn[6:0] == OPC_OP_IMM_32);
        5'b01100, 5'b10100, 5'b11100, 5'b10101: func_ok = SBOP;
        5'b00101: func_ok = BFP;
        default:  func_ok = 1'b0;
      endcase
    end
    // There is no rotate-left-immediate; software uses RORI instead.
    rol_imm = (insn[6:0] == OPC_OP_IMM) && !insn[27] && !insn[26] &&
              insn[30] && insn[29] && !insn[14];
    // insn[3] marks the *W opcodes, which do not exist on RV32.
    w_bad = !IS_RV64 && insn[3];
    return opc_ok && f3_ok && func_ok && !rol_imm && !w_bad;
  endfunction

  // Second shifter operand: register value, or the zero-extended shamt field
  // for immediate forms (5 bits on RV32 and for *W, 6 bits otherwise).
  function automatic logic [XLEN-1:0] sel_rs2(input logic [31:0]     insn,
                                               input logic [XLEN-1:0] rs2);
    logic [XLEN-1:0] val;
    val = rs2;
    if (!insn[5]) begin
      if (!IS_RV64 || insn[3]) begin
        val = {{(XLEN-5){1'b0}}, insn[24:20]};
      end else begin
        val = {{(XLEN-6){1'b0}}, insn[25:20]};
      end
    end else begin
      val = rs2;
    end
    return val;
  endfunction

  entry_t      mem_r [2];
  logic        wr_ptr_r;
  logic        rd_ptr_r;
  logic [1:0]  count_r;
  logic        in_ready_r;
  logic        dout_valid_r;
  logic        err_valid_r;
  logic [31:0] err_insn_r;

  logic        accept_s;
  logic        legal_s;
  logic        push_s;
  logic        pop_s;
  logic [1:0]  count_nxt_s;
  entry_t      new_entry_s;
  entry_t      head_s;

  // Handshake decode, occupancy update and the entry to be written.
  always_comb begin
    accept_s    = bus.in_valid && in_ready_r;
    legal_s     = is_legal(bus.in_insn);
    push_s      = accept_s && legal_s;
    pop_s       = dout_valid_r && bus.dout_ready;
    count_nxt_s = count_r;
    if (push_s && !pop_s) begin
      count_nxt_s = count_r + 2'd1;
    end else if (pop_s && !push_s) begin
      count_nxt_s = count_r - 2'd1;
    end else begin
      count_nxt_s = count_r;
    end
    new_entry_s.rs1  = bus.in_rs1;
    new_entry_s.rs2  = sel_rs2(bus.in_insn, bus.in_rs2);
    new_entry_s.rs3  = bus.in_rs3;
    new_entry_s.ctrl = {bus.in_insn[3],  bus.in_insn[14], bus.in_insn[26],
                        bus.in_insn[27], bus.in_insn[29], bus.in_insn[30]};
  end

  // FIFO storage, pointers, occupancy, registered ready/valid and error report.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      mem_r[0]     <= '0;
      mem_r[1]     <= '0;
      wr_ptr_r     <= 1'b0;
      rd_ptr_r     <= 1'b0;
      count_r      <= 2'd0;
      in_ready_r   <= 1'b1;
      dout_valid_r <= 1'b0;
      err_valid_r  <= 1'b0;
      err_insn_r   <= 32'd0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= new_entry_s;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      count_r      <= count_nxt_s;
      // Both flags come from the next occupancy, so ready/valid are pure flops.
      in_ready_r   <= (count_nxt_s != 2'd2);
      dout_valid_r <= (count_nxt_s != 2'd0);
      err_valid_r  <= accept_s && !legal_s;
      if (accept_s && !legal_s) begin
        err_insn_r <= bus.in_insn;
      end
    end
  end

  // The head entry is a register selected by the read pointer; nothing from in_*.
  always_comb begin
    head_s = mem_r[rd_ptr_r];
  end

  assign bus.in_ready    = in_ready_r;
  assign bus.dout_valid  = dout_valid_r;
  assign bus.dout_rs1    = head_s.rs1;
  assign bus.dout_rs2    = head_s.rs2;
  assign bus.dout_rs3    = head_s.rs3;
  assign bus.dout_insn3  = head_s.ctrl[5];
  assign bus.dout_insn14 = head_s.ctrl[4];
  assign bus.dout_insn26 = head_s.ctrl[3];
  assign bus.dout_insn27 = head_s.ctrl[2];
  assign bus.dout_insn29 = head_s.ctrl[1];
  assign bus.dout_insn30 = head_s.ctrl[0];
  assign bus.err_valid   = err_valid_r;
  assign bus.err_insn    = err_insn_r;

`ifdef RVB_SHIFTER_ISSUE_PERF_EN
  logic [31:0] perf_issued_r;
  logic [31:0] perf_illegal_r;
  logic [31:0] perf_stall_r;

  // Free-running event counters; they wrap naturally at 2^32.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      perf_issued_r  <= 32'd0;
      perf_illegal_r <= 32'd0;
      perf_stall_r   <= 32'd0;
    end else begin
      if (push_s) begin
        perf_issued_r <= perf_issued_r + 32'd1;
      end
      if (accept_s && !legal_s) begin
        perf_illegal_r <= perf_illegal_r + 32'd1;
      end
      if (dout_valid_r && !bus.dout_ready) begin
        perf_stall_r <= perf_stall_r + 32'd1;
      end
    end
  end

  assign perf_issued  = perf_issued_r;
  assign perf_illegal = perf_illegal_r;
  assign perf_stall   = perf_stall_r;
`endif

endmodule
